sort_fifo_reader: RTL
=====================

# sort_fifo_reader

Downstream drain stage for the AXI4-Lite packet validator/sorter. It receives sorted 32-bit packets on a push port, one per cycle, each tagged valid (header byte 0xA5) or invalid. Packets go into two independent circular FIFOs. A host drains those FIFOs through an AXI4-Lite read channel (AR/R). A status word is also readable, so software can see occupancy and overflow without popping data.

## Interface
Parameters:
- WIDTH, 32, data width of packets and RDATA
- DEPTH, 8, entries per FIFO; power of two, 2..128
- PTR_W, $clog2(DEPTH), pointer width; occupancy counters are PTR_W+1 bits

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- push_en  input  1  push strobe from the sorter
- push_valid  input  1  1 = push into valid FIFO, 0 = push into invalid FIFO
- push_data  input  WIDTH  packet to store
- ARADDR  input  32  read address
- ARVALID  input  1  read address valid
- ARREADY  output  1  read address ready
- RDATA  output  WIDTH  read data
- RRESP  output  2  read response
- RVALID  output  1  read data valid
- RREADY  input  1  master ready for read data
- val_count  output  PTR_W+1  valid FIFO occupancy
- ival_count  output  PTR_W+1  invalid FIFO occupancy
- val_full, val_empty, ival_full, ival_empty  output  1 each  flags derived from the counts
- overflow  output  1  sticky flag: a push was dropped

## Operation
- Address map:
  - 0x00: pop the valid FIFO.
  - 0x04: pop the invalid FIFO.
  - 0x08: status register (only with the macro below).
  - Any other address: DECERR (2'b11), RDATA = 0, nothing popped.
- Push:
  - When push_en=1, the target FIFO is selected by push_valid.
  - If the target is not full, write push_data at its write pointer, then increment the pointer (wraps DEPTH-1 -> 0) and the count.
  - If the target is full, drop the packet and set overflow. The full check uses the pre-cycle count, so a push to a full FIFO is dropped even if the same FIFO pops that cycle.
- Read FSM, two states:
  - IDLE: ARREADY = ~rst. On ARVALID & ARREADY, decode ARADDR and register RDATA/RRESP, then go to RESP.
  - RESP: ARREADY=0, RVALID=1. RDATA and RRESP are held stable until RREADY; then return to IDLE.
- Pop, performed in the accept cycle:
  - FIFO not empty: RDATA = entry at the read pointer, RRESP = OKAY (2'b00), read pointer increments (wraps) and count decrements.
  - FIFO empty: RDATA = 0, RRESP = SLVERR (2'b10), no pointer change.
- Push and pop to the same FIFO in the same cycle:
  - Both take effect; the count is unchanged.
  - If the FIFO was empty at accept, the pop reports SLVERR and the push is still stored.
- Counts never exceed DEPTH and never underflow.

## Timing
- Reset values: ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00, both counts 0, both pointers 0, overflow=0, val_empty=ival_empty=1, val_full=ival_full=0, FSM in IDLE. FIFO storage is not cleared.
- ARREADY is 1 in the first cycle after rst deasserts.
- Read latency: AR accepted at edge N -> RVALID=1 from edge N. Minimum one cycle per transaction, plus cycles RREADY is held low. Back-to-back accepts have at least one idle cycle between them (ARREADY returns in the cycle after the R handshake).
- Push latency: a push at edge N is visible in the counts after edge N and is poppable by an AR accepted at edge N+1 or later.
- rst asserted mid-transaction: at the next edge, RVALID drops and everything returns to reset values; the in-flight read is lost.

## Configuration
- SORT_RD_STATUS_EN defined:
  - 0x08 returns OKAY with RDATA = {8'hA5, 3'b0, overflow, ival_empty, val_empty, ival_full, val_full, ival_count zero-extended to 8, val_count zero-extended to 8}.
  - The read clears overflow at the accept edge. If a drop occurs in that same cycle, the set wins.
- Undefined: 0x08 decodes as DECERR and overflow can only be cleared by rst.

## Test plan
- Reset, then read 0x00 -> RRESP=2'b10, RDATA=0, val_count stays 0, ARREADY high the cycle after the handshake.
- Push 0xA5000001, 0xA5000002 (valid) and 0x11000003 (invalid), then read 0x00 twice and 0x04 once -> 0xA5000001, 0xA5000002, 0x11000003, all OKAY, counts return to 0.
- Push 9 valid packets with DEPTH=8 -> val_full=1, overflow=1, 9th dropped. Read 8 -> original order including the wrap. 9th read -> SLVERR.
- Hold RREADY low 5 cycles after the AR handshake -> RVALID and RDATA stable for all 5 cycles, no further pop.
- Push to the valid FIFO in the same cycle an AR to 0x00 is accepted with count=3 -> val_count stays 3. With count=0 -> SLVERR and count becomes 1.
- With SORT_RD_STATUS_EN, after an overflow, read 0x08 -> RDATA[31:24]=0xA5, bit20=1. Second read -> bit20=0. Read 0x0C -> DECERR.

Source files
------------

// File: rtl/sort_fifo_reader.sv
// -----------------------------------------------------------------------------
// sort_fifo_reader
//
// Drain stage behind the packet validator/sorter. Sorted packets arrive on a
// push port, one per cycle. Each packet goes into one of two circular FIFOs:
// the "valid" FIFO or the "invalid" FIFO. A host drains the FIFOs through an
// AXI4-Lite read channel (AR/R only).
//
// Address map
//   0x00  pop the valid FIFO   (SLVERR with RDATA=0 when empty)
//   0x04  pop the invalid FIFO (SLVERR with RDATA=0 when empty)
//   0x08  status word          (only when SORT_RD_STATUS_EN is defined)
//   other DECERR, RDATA=0, nothing popped
//
// Optional feature macro: SORT_RD_STATUS_EN
//   When defined, 0x08 returns
//     {8'hA5, 3'b0, overflow, ival_empty, val_empty, ival_full, val_full,
//      ival_count (8 bits), val_count (8 bits)}
//   and reading it clears the sticky overflow flag (a same-cycle drop wins).
//   When undefined, 0x08 decodes as DECERR and only rst clears overflow.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   push_en/push_valid       push strobe and FIFO select (1 = valid FIFO)
//   push_data [WIDTH]        packet to store
//   ARADDR/ARVALID/ARREADY   AXI4-Lite read address channel
//   RDATA/RRESP/RVALID/RREADY AXI4-Lite read data channel
//   val_count/ival_count     FIFO occupancies (PTR_W+1 bits)
//   val_full/val_empty/ival_full/ival_empty  flags derived from the counts
//   overflow                 sticky: a push was dropped because of a full FIFO
// -----------------------------------------------------------------------------
module sort_fifo_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_en,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic [31:0]      ARADDR,
  input  logic             ARVALID,
  output logic             ARREADY,
  output logic [WIDTH-1:0] RDATA,
  output logic [1:0]       RRESP,
  output logic             RVALID,
  input  logic             RREADY,
  output logic [PTR_W:0]   val_count,
  output logic [PTR_W:0]   ival_count,
  output logic             val_full,
  output logic             val_empty,
  output logic             ival_full,
  output logic             ival_empty,
  output logic             overflow
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0] state;

  logic [WIDTH-1:0] val_mem  [DEPTH];
  logic [WIDTH-1:0] ival_mem [DEPTH];

  logic [PTR_W-1:0] val_wr_ptr, val_rd_ptr;
  logic [PTR_W-1:0] ival_wr_ptr, ival_rd_ptr;

  logic accept;
  logic sel_val, sel_ival;
  logic val_push_ok, ival_push_ok, drop;
  logic val_pop_ok, ival_pop_ok;

  logic [WIDTH-1:0] rd_data_nxt;
  logic [1:0]       rd_resp_nxt;

  assign val_full   = (val_count == FULL_CNT);
  assign ival_full  = (ival_count == FULL_CNT);
  assign val_empty  = (val_count == '0);
  assign ival_empty = (ival_count == '0);

  // ARREADY is combinational so it is low throughout reset and high in the
  // very first cycle after reset is released.
  assign ARREADY = (state == ST_IDLE) && !rst;
  assign RVALID  = (state == ST_RESP);
  assign accept  = ARVALID && ARREADY;

  assign sel_val  = (ARADDR == 32'h0000_0000);
  assign sel_ival = (ARADDR == 32'h0000_0004);

  // Full/empty decisions use the counts from before this edge, so a push to a
  // full FIFO is dropped even if that FIFO pops in the same cycle, and a pop
  // of an empty FIFO errors even if that FIFO is pushed in the same cycle.
  assign val_push_ok  = push_en && push_valid && !val_full;
  assign ival_push_ok = push_en && !push_valid && !ival_full;
  assign drop         = push_en && (push_valid ? val_full : ival_full);
  assign val_pop_ok   = accept && sel_val && !val_empty;
  assign ival_pop_ok  = accept && sel_ival && !ival_empty;

`ifdef SORT_RD_STATUS_EN
  logic        sel_stat;
  logic [31:0] status_word;

  assign sel_stat    = (ARADDR == 32'h0000_0008);
  assign status_word = {8'hA5, 3'b000, overflow, ival_empty, val_empty,
                        ival_full, val_full, 8'(ival_count), 8'(val_count)};
`endif

  // Response decode for the address presented in the accept cycle.
  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = RESP_DECERR;
    if (sel_val) begin
      if (!val_empty) begin
        rd_data_nxt = val_mem[val_rd_ptr];
        rd_resp_nxt = RESP_OKAY;
      end else begin
        rd_resp_nxt = RESP_SLVERR;
      end
    end else if (sel_ival) begin
      if (!ival_empty) begin
        rd_data_nxt = ival_mem[ival_rd_ptr];
        rd_resp_nxt = RESP_OKAY;
      end else begin
        rd_resp_nxt = RESP_SLVERR;
      end
    end
`ifdef SORT_RD_STATUS_EN
    else if (sel_stat) begin
      rd_data_nxt = WIDTH'(status_word);
      rd_resp_nxt = RESP_OKAY;
    end
`endif
  end

  // Read FSM: RDATA/RRESP are captured at accept and held until RREADY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      RDATA <= '0;
      RRESP <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            RDATA <= rd_data_nxt;
            RRESP <= rd_resp_nxt;
            state <= ST_RESP;
          end
        end
        default: begin
          if (RREADY) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // FIFO storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (val_push_ok) begin
      val_mem[val_wr_ptr] <= push_data;
    end
    if (ival_push_ok) begin
      ival_mem[ival_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_wr_ptr  <= '0;
      val_rd_ptr  <= '0;
      ival_wr_ptr <= '0;
      ival_rd_ptr <= '0;
      val_count   <= '0;
      ival_count  <= '0;
    end else begin
      if (val_push_ok)  val_wr_ptr  <= val_wr_ptr + PTR_ONE;
      if (val_pop_ok)   val_rd_ptr  <= val_rd_ptr + PTR_ONE;
      if (ival_push_ok) ival_wr_ptr <= ival_wr_ptr + PTR_ONE;
      if (ival_pop_ok)  ival_rd_ptr <= ival_rd_ptr + PTR_ONE;

      if (val_push_ok && !val_pop_ok) begin
        val_count <= val_count + CNT_ONE;
      end else if (val_pop_ok && !val_push_ok) begin
        val_count <= val_count - CNT_ONE;
      end

      if (ival_push_ok && !ival_pop_ok) begin
        ival_count <= ival_count + CNT_ONE;
      end else if (ival_pop_ok && !ival_push_ok) begin
        ival_count <= ival_count - CNT_ONE;
      end
    end
  end

  // Sticky overflow; with the status feature a status read clears it, but a
  // drop in the same cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
`ifdef SORT_RD_STATUS_EN
    else if (accept && sel_stat) begin
      overflow <= 1'b0;
    end
`endif
  end

endmodule
